// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - field layout, limits and FSM state encoding shared by the normalizer
package fp_pkg;

    localparam int MANT_W   = 23;
    localparam int EXP_W    = 8;
    localparam int MANT_LSB = 9;
    localparam int EXP_LSB  = 1;
    localparam int SIGN_BIT = 0;

    localparam logic [EXP_W-1:0]  EXP_MAX   = 8'd255;
    localparam logic [MANT_W-1:0] MANT_HALF = 23'h400000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/fp_norm_shift.sv
// rtl/fp_norm_shift.sv - one combinational left-normalization step (shift amount, next mantissa, done)
module fp_norm_shift
    import fp_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic [MANT_W-1:0] mant_i,
    input  logic [EXP_W-1:0]  exp_i,
    output logic [1:0]        shamt_o,
    output logic [MANT_W-1:0] mant_o,
    output logic              done_o
);

    logic [EXP_W-1:0] exp_nxt;

    // An exponent already at zero cannot be shifted further; otherwise take a 1- or 2-bit step
    always_comb begin
        shamt_o = 2'd0;
        mant_o  = mant_i;
        exp_nxt = exp_i;
        done_o  = 1'b0;
        if (exp_i == '0) begin
            done_o = 1'b1;
        end else begin
            if (STEP == 2 && mant_i[MANT_W-1:MANT_W-2] == 2'b00 && exp_i >= 8'd2)
                shamt_o = 2'd2;
            else
                shamt_o = 2'd1;
            mant_o  = mant_i << shamt_o;
            exp_nxt = exp_i - {6'd0, shamt_o};
            done_o  = mant_o[MANT_W-1] || (exp_nxt == '0);
        end
    end

endmodule

// File: rtl/fp_normalize.sv
// rtl/fp_normalize.sv - post-add normalizer FSM; FP_NORMALIZE_ROUND_EN enables round-half-up on carry shift
module fp_normalize
    import fp_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_carry,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        out_zero
);

    state_e            state_q, state_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              sign_q, sign_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              zero_q, zero_d;

    logic [MANT_W-1:0] in_mant;
    logic [EXP_W-1:0]  in_exp;
    logic              in_sign;

    logic [MANT_W-1:0] cy_mant;
    logic [EXP_W-1:0]  cy_exp;
    logic              cy_ovf;

    logic [1:0]        sh_amt;
    logic [MANT_W-1:0] sh_mant;
    logic              sh_done;

    assign in_mant = in_data[MANT_LSB +: MANT_W];
    assign in_exp  = in_data[EXP_LSB +: EXP_W];
    assign in_sign = in_data[SIGN_BIT];

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = {mant_q, exp_q, sign_q};
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;
    assign out_zero  = zero_q;

    fp_norm_shift #(.STEP(STEP)) u_shift (
        .mant_i  (mant_q),
        .exp_i   (exp_q),
        .shamt_o (sh_amt),
        .mant_o  (sh_mant),
        .done_o  (sh_done)
    );

    // Carry-out path: fold the carry back in as the new leading one and bump the exponent
    always_comb begin
        cy_mant = {1'b1, in_mant[MANT_W-1:1]};
        cy_exp  = in_exp + 8'd1;
        cy_ovf  = (in_exp == EXP_MAX);
`ifdef FP_NORMALIZE_ROUND_EN
        if (in_mant[0]) begin
            if (&cy_mant) begin
                cy_mant = MANT_HALF;
                if (cy_exp == EXP_MAX)
                    cy_ovf = 1'b1;
                else
                    cy_exp = cy_exp + 8'd1;
            end else begin
                cy_mant = cy_mant + 23'd1;
            end
        end
`endif
        if (cy_ovf) begin
            cy_mant = '0;
            cy_exp  = EXP_MAX;
        end
    end

    // Next-state and datapath selection for IDLE accept, SHIFT steps and DONE handoff
    always_comb begin
        state_d = state_q;
        mant_d  = mant_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    zero_d = 1'b0;
                    mant_d = in_mant;
                    exp_d  = in_exp;
                    if (in_carry) begin
                        mant_d  = cy_mant;
                        exp_d   = cy_exp;
                        ovf_d   = cy_ovf;
                        state_d = ST_DONE;
                    end else if (in_mant == '0) begin
                        exp_d   = '0;
                        zero_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (in_mant[MANT_W-1]) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                mant_d = sh_mant;
                exp_d  = exp_q - {6'd0, sh_amt};
                if (sh_done) begin
                    unf_d   = ~sh_mant[MANT_W-1];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset that drops any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mant_q  <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mant_q  <= mant_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_fp_normalize.sv
// tb/tb_fp_normalize.sv - scoreboard bench for fp_normalize (STEP=1)
module tb_fp_normalize;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_unf;
    logic        out_zero;

    int errors = 0;
    int checks = 0;

    logic [31:0] sb_data[$];
    logic [2:0]  sb_flags[$];
    int          sb_lat[$];

    always #5 clk = ~clk;

    fp_normalize #(.STEP(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_zero  (out_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference for STEP=1; flags packed {ovf,unf,zero}
    task automatic model(input logic [22:0] m_in, input logic [7:0] e_in, input logic s,
                         input logic c, output logic [31:0] d, output logic [2:0] f, output int lat);
        logic [22:0] m;
        logic [7:0]  e;
        int          n;
        m = m_in; e = e_in; f = 3'b000; n = 0;
        if (c) begin
            if (e == 8'd255) begin
                m = '0; f[2] = 1'b1;
            end else begin
                m = {1'b1, m_in[22:1]};
                e = e + 8'd1;
`ifdef FP_NORMALIZE_ROUND_EN
                if (m_in[0]) begin
                    if (m == 23'h7FFFFF) begin
                        m = 23'h400000;
                        if (e == 8'd255) begin m = '0; f[2] = 1'b1; end
                        else e = e + 8'd1;
                    end else begin
                        m = m + 23'd1;
                    end
                end
`endif
            end
        end else if (m == '0) begin
            e = '0; f[0] = 1'b1;
        end else if (!m[22]) begin
            forever begin
                n++;
                if (e == '0) begin f[1] = 1'b1; break; end
                m = m << 1;
                e = e - 8'd1;
                if (m[22]) break;
                if (e == '0) begin f[1] = 1'b1; break; end
            end
        end
        d = {m, e, s};
        lat = 1 + n;
    endtask

    task automatic expect_out(input logic [31:0] d, input logic [2:0] f, input int lat);
        sb_data.push_back(d);
        sb_flags.push_back(f);
        sb_lat.push_back(lat);
    endtask

    task automatic drive(input logic [22:0] m, input logic [7:0] e, input logic s, input logic c);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = {m, e, s};
        in_carry = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_carry = 1'b0;
        in_data  = '0;
    endtask

    task automatic drive_model(input logic [22:0] m, input logic [7:0] e, input logic s, input logic c);
        logic [31:0] d;
        logic [2:0]  f;
        int          lat;
        model(m, e, s, c, d, f, lat);
        expect_out(d, f, lat);
        drive(m, e, s, c);
    endtask

    // Called right after the accept edge (+1); waits for the result, compares, then hands it off
    task automatic collect(input int hold);
        int          lat = 1;
        logic [31:0] xd;
        logic [2:0]  xf;
        int          xl;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("out_valid_rise", {31'd0, out_valid}, 32'd1);
        if (sb_data.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            xd = sb_data.pop_front();
            xf = sb_flags.pop_front();
            xl = sb_lat.pop_front();
            check("out_data", out_data, xd);
            check("flags", {29'd0, out_ovf, out_unf, out_zero}, {29'd0, xf});
            check("latency", lat, xl);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", out_data, xd);
                check("hold_flags", {29'd0, out_ovf, out_unf, out_zero}, {29'd0, xf});
                check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handoff_valid_low", {31'd0, out_valid}, 32'd0);
        check("handoff_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic        seen;
        logic [22:0] rm;
        logic [7:0]  re;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_carry = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_flags", {29'd0, out_ovf, out_unf, out_zero}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // one-step normalize, held 5 cycles before acceptance
        expect_out({23'h400000, 8'd9, 1'b0}, 3'b000, 2);
        drive(23'h200000, 8'd10, 1'b0, 1'b0);
        collect(5);

        // carry right-shift
`ifdef FP_NORMALIZE_ROUND_EN
        expect_out({23'h400001, 8'd6, 1'b0}, 3'b000, 1);
`else
        expect_out({23'h400000, 8'd6, 1'b0}, 3'b000, 1);
`endif
        drive(23'h000001, 8'd5, 1'b0, 1'b1);
        collect(0);

        // zero result keeps sign
        expect_out({23'h0, 8'd0, 1'b1}, 3'b001, 1);
        drive(23'h0, 8'd77, 1'b1, 1'b0);
        collect(0);

        // underflow with partial shift
        expect_out({23'h000008, 8'd0, 1'b1}, 3'b010, 4);
        drive(23'h000001, 8'd3, 1'b1, 1'b0);
        collect(0);

        // overflow on carry at EXP_MAX
        expect_out({23'h0, 8'd255, 1'b0}, 3'b100, 1);
        drive(23'h000123, 8'd255, 1'b0, 1'b1);
        collect(0);

        // already normalized passes unchanged
        expect_out({23'h400123, 8'd200, 1'b1}, 3'b000, 1);
        drive(23'h400123, 8'd200, 1'b1, 1'b0);
        collect(0);

        // exp already zero on SHIFT entry: no shift, underflow
        expect_out({23'h000005, 8'd0, 1'b0}, 3'b010, 2);
        drive(23'h000005, 8'd0, 1'b0, 1'b0);
        collect(0);

        // carry with all-ones mantissa into exp 255
`ifdef FP_NORMALIZE_ROUND_EN
        expect_out({23'h0, 8'd255, 1'b0}, 3'b100, 1);
`else
        expect_out({23'h7FFFFF, 8'd255, 1'b0}, 3'b000, 1);
`endif
        drive(23'h7FFFFF, 8'd254, 1'b0, 1'b1);
        collect(0);

        // randomized vectors against the reference
        for (int i = 0; i < 8; i++) begin
            rm = 23'($urandom_range(0, 32'h7FFFFF) >> $urandom_range(0, 22));
            re = 8'($urandom_range(0, 40));
            drive_model(rm, re, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            collect(i % 2);
        end

        // reset in the middle of SHIFT drops the operation
        drive(23'h000001, 8'd3, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midshift_rst_valid", {31'd0, out_valid}, 32'd0);
        check("midshift_rst_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midshift_no_output", {31'd0, seen}, 32'd0);

        check("scoreboard_drained", sb_data.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
